// File: rtl/vga_pkg.sv
// Shared VGA timing types, default 640x480@60 timing and window-decode helper.
package vga_pkg;

  localparam int unsigned COORD_W   = 11;
  localparam int unsigned CMP_W     = COORD_W + 1;
  localparam int unsigned MAX_TOTAL = 2048;

  typedef logic [COORD_W-1:0] vga_coord_t;

  localparam int unsigned DEF_H_ACTIVE   = 640;
  localparam int unsigned DEF_H_FP       = 16;
  localparam int unsigned DEF_H_SYNC     = 96;
  localparam int unsigned DEF_H_BP       = 48;
  localparam int unsigned DEF_V_ACTIVE   = 480;
  localparam int unsigned DEF_V_FP       = 10;
  localparam int unsigned DEF_V_SYNC     = 2;
  localparam int unsigned DEF_V_BP       = 33;
  localparam logic        DEF_HS_POL     = 1'b0;
  localparam logic        DEF_VS_POL     = 1'b0;
  localparam int unsigned DEF_SYNC_DELAY = 1;

  // True when lo <= c < lo+len; compared one bit wider so a window ending at 2048 works.
  function automatic logic in_window(vga_coord_t c, int unsigned lo, int unsigned len);
    logic [CMP_W-1:0] cw;
    cw = {1'b0, c};
    return (cw >= CMP_W'(lo)) && (cw < CMP_W'(lo + len));
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with active-region and sync-window decode.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output vga_coord_t count,
  output logic       wrap,
  output logic       active,
  output logic       sync_raw
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;
  localparam vga_coord_t  LAST  = COORD_W'(TOTAL - 1);

  if (TOTAL > MAX_TOTAL) begin : g_total_chk
    $error("vga_axis_counter: total %0d exceeds %0d", TOTAL, MAX_TOTAL);
  end
  if (ACTIVE < 1 || SYNC < 1) begin : g_min_chk
    $error("vga_axis_counter: ACTIVE and SYNC must be at least 1");
  end

  assign wrap     = step && (count == LAST);
  assign active   = in_window(count, 0, ACTIVE);
  assign sync_raw = in_window(count, ACTIVE + FP, SYNC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (step) begin
      count <= wrap ? '0 : count + COORD_W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: axis counters, registered row/column/en/strobes and a delayed sync pipeline.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter logic        HS_POL     = DEF_HS_POL,
  parameter logic        VS_POL     = DEF_VS_POL,
  parameter int unsigned SYNC_DELAY = DEF_SYNC_DELAY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output vga_coord_t column,
  output vga_coord_t row,
  output logic       en,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned SD_W = SYNC_DELAY + 1;

  if (SYNC_DELAY > 4) begin : g_delay_chk
    $error("vga_timing_gen: SYNC_DELAY %0d out of range 0..4", SYNC_DELAY);
  end

  vga_coord_t h_cnt, v_cnt;
  logic       h_wrap, h_active, h_sync_raw;
  logic       v_wrap_unused, v_active, v_sync_raw;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk      (clk),
    .rst      (rst),
    .step     (pix_en),
    .count    (h_cnt),
    .wrap     (h_wrap),
    .active   (h_active),
    .sync_raw (h_sync_raw)
  );

  // Lines advance only on the tick that wraps the horizontal counter.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk      (clk),
    .rst      (rst),
    .step     (pix_en & h_wrap),
    .count    (v_cnt),
    .wrap     (v_wrap_unused),
    .active   (v_active),
    .sync_raw (v_sync_raw)
  );

  logic [SYNC_DELAY:0] hs_q, vs_q;
  logic                hs_next, vs_next;

  assign hs_next = h_sync_raw ? HS_POL : ~HS_POL;
  assign vs_next = v_sync_raw ? VS_POL : ~VS_POL;
  assign hsync   = hs_q[SYNC_DELAY];
  assign vsync   = vs_q[SYNC_DELAY];

  // Stage 0 aligns with column/row; higher stages add pixel-tick delay for the RGB register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      column      <= '0;
      row         <= '0;
      en          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hs_q        <= {SD_W{~HS_POL}};
      vs_q        <= {SD_W{~VS_POL}};
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        column      <= h_cnt;
        row         <= v_cnt;
        en          <= h_active && v_active;
        line_start  <= (h_cnt == '0);
        frame_start <= (h_cnt == '0) && (v_cnt == '0);
        hs_q        <= SD_W'({hs_q, hs_next});
        vs_q        <= SD_W'({vs_q, vs_next});
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a small raster and a tick-count reference model.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int unsigned H_ACTIVE = 10;
  localparam int unsigned H_FP     = 2;
  localparam int unsigned H_SYNC   = 3;
  localparam int unsigned H_BP     = 0;
  localparam int unsigned V_ACTIVE = 6;
  localparam int unsigned V_FP     = 1;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 3;
  localparam logic        HS_POL   = 1'b0;
  localparam logic        VS_POL   = 1'b1;
  localparam int unsigned SD       = 2;
  localparam int unsigned HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned FRAME    = HT * VT;

  typedef struct packed {
    logic [COORD_W-1:0] column;
    logic [COORD_W-1:0] row;
    logic en;
    logic hsync;
    logic vsync;
    logic ls;
    logic fs;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_en = 1'b0;
  vga_coord_t column, row;
  logic       en, hsync, vsync, line_start, frame_start;

  obs_t        exp_q[$];
  obs_t        last_exp;
  int unsigned tick = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          in_reset = 1'b1;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .SYNC_DELAY(SD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .column      (column),
    .row         (row),
    .en          (en),
    .hsync       (hsync),
    .vsync       (vsync),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic obs_t reset_val();
    obs_t r;
    r = '0;
    r.hsync = ~HS_POL;
    r.vsync = ~VS_POL;
    return r;
  endfunction

  // Expected outputs after the k-th pixel tick since reset (k starts at 0).
  function automatic obs_t model(int unsigned k);
    obs_t        e;
    int unsigned p, c, r, sp, sc, sr;
    p = k % FRAME;
    c = p % HT;
    r = p / HT;
    e.column = COORD_W'(c);
    e.row    = COORD_W'(r);
    e.en     = (c < H_ACTIVE) && (r < V_ACTIVE);
    e.ls     = (c == 0);
    e.fs     = (p == 0);
    if (k < SD) begin
      e.hsync = ~HS_POL;
      e.vsync = ~VS_POL;
    end else begin
      sp = (k - SD) % FRAME;
      sc = sp % HT;
      sr = sp / HT;
      e.hsync = (sc >= H_ACTIVE + H_FP && sc < H_ACTIVE + H_FP + H_SYNC) ? HS_POL : ~HS_POL;
      e.vsync = (sr >= V_ACTIVE + V_FP && sr < V_ACTIVE + V_FP + V_SYNC) ? VS_POL : ~VS_POL;
    end
    return e;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.column = column;
    o.row    = row;
    o.en     = en;
    o.hsync  = hsync;
    o.vsync  = vsync;
    o.ls     = line_start;
    o.fs     = frame_start;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got col=%0d row=%0d en=%b hs=%b vs=%b ls=%b fs=%b, expected col=%0d row=%0d en=%b hs=%b vs=%b ls=%b fs=%b",
               name, $time, act.column, act.row, act.en, act.hsync, act.vsync, act.ls, act.fs,
               exp.column, exp.row, exp.en, exp.hsync, exp.vsync, exp.ls, exp.fs);
    end
  endtask

  // Drive pix_en for the next rising edge and record what that tick must show.
  task automatic step_cycle(input bit pe);
    @(negedge clk);
    pix_en = pe;
    if (pe) begin
      exp_q.push_back(model(tick));
      tick++;
    end
  endtask

  // Monitor: pix_en ticks pop the scoreboard; idle cycles must hold state with strobes low.
  initial begin
    obs_t e;
    bit   pe;
    forever begin
      @(posedge clk);
      pe = pix_en;
      #1;
      if (!in_reset) begin
        if (pe) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_underflow @%0t: got empty queue, expected an entry", $time);
          end else begin
            e = exp_q.pop_front();
            check("tick", dut_obs(), e);
            last_exp = e;
          end
        end else begin
          e    = last_exp;
          e.ls = 1'b0;
          e.fs = 1'b0;
          check("hold", dut_obs(), e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    last_exp = reset_val();
    #12;
    check("reset_initial", dut_obs(), reset_val());
    @(negedge clk);
    rst      = 1'b0;
    in_reset = 1'b0;

    step_cycle(1'b0);
    for (int i = 0; i < 2 * FRAME + 40; i++) step_cycle(1'b1);
    for (int i = 0; i < 1500; i++) step_cycle(1'($urandom_range(0, 1)));
    for (int i = 0; i < 4 * FRAME; i++) step_cycle((i % 4) == 0);
    for (int i = 0; i < 37; i++) step_cycle(1'b1);

    // Asynchronous reset mid-frame, checked before any further clock edge.
    @(negedge clk);
    pix_en   = 1'b0;
    in_reset = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", dut_obs(), reset_val());
    exp_q.delete();
    tick     = 0;
    last_exp = reset_val();
    repeat (2) @(negedge clk);
    check("reset_held", dut_obs(), reset_val());
    rst      = 1'b0;
    in_reset = 1'b0;

    for (int i = 0; i < FRAME + 20; i++) step_cycle(1'b1);
    for (int i = 0; i < 200; i++) step_cycle(($urandom_range(0, 3)) == 0);
    step_cycle(1'b0);
    @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates VGA raster timing for the display pipeline: free-running horizontal/vertical pixel counters, the `row`/`column`/`en` triple consumed by the RGB output stage, and horizontal and vertical sync pulses. The RGB output stage registers colour, adding one cycle of delay. The sync pulses carry a matching configurable delay so sync and colour reach the connector aligned. It sits directly upstream of the RGB output stage and of the pixel/colour source.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HS_POL`, 0, hsync active level
- `VS_POL`, 0, vsync active level
- `SYNC_DELAY`, 1, extra pixel-tick register stages on hsync/vsync (0..4)
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `pix_en`  in  1  pixel tick; state advances only on cycles with `pix_en`=1
- `column`  out  11  current pixel x
- `row`  out  11  current pixel y
- `en`  out  1  video active (column<H_ACTIVE and row<V_ACTIVE)
- `hsync`  out  1  horizontal sync, polarity HS_POL
- `vsync`  out  1  vertical sync, polarity VS_POL
- `line_start`  out  1  one-clk pulse when outputs show column=0
- `frame_start`  out  1  one-clk pulse when outputs show column=0, row=0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL defined likewise (default 525).
- Elaboration check: each total ≤ 2048. Each parameter ≥ 1, except the porches, which may be 0.
- Internal counters `h_cnt`, `v_cnt`, both 11 bits unsigned.
- On a `pix_en` cycle, `h_cnt` increments and wraps from H_TOTAL-1 to 0.
- `v_cnt` increments only when `h_cnt` wraps, and wraps from V_TOTAL-1 to 0.
- Output register stage, loaded on `pix_en` cycles from the pre-increment counter values:
  - `column`=h_cnt, `row`=v_cnt
  - `en`=(h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE)
  - `line_start`=(h_cnt==0); `frame_start`=(h_cnt==0&&v_cnt==0)
- Sync decode is registered in the same stage, then passes through SYNC_DELAY further `pix_en`-qualified registers:
  - hsync active for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC (default 656..751).
  - vsync active for V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC (default 490..491).
- vsync switches on the same tick as the hsync-decode line boundary (column 0 of the line), not mid-line.
- `line_start`/`frame_start` are forced to 0 on any clk cycle with `pix_en`=0. They are never wider than one clk.
- `pix_en` held at 1 means one pixel per clk.

## Timing
- Reset values, applied asynchronously:
  - `h_cnt`=0, `v_cnt`=0, `column`=0, `row`=0
  - `en`=0, `line_start`=0, `frame_start`=0
  - `hsync`=~HS_POL, `vsync`=~VS_POL, all sync delay stages likewise inactive
- Reset asserted mid-frame forces all outputs to these values immediately, with no clk edge required.
- After reset release, the first `pix_en` edge presents column=0, row=0, en=1, line_start=1, frame_start=1.
- Latency: `column`/`row`/`en` lag the counters by 1 tick. `hsync`/`vsync` lag `column`/`row` by SYNC_DELAY ticks.
- Simultaneous h-wrap and v-wrap at (H_TOTAL-1, V_TOTAL-1): the next tick shows (0,0) with frame_start=1.
- `pix_en`=0 holds every register, including the sync delay pipeline.

## Structure
- Package `vga_pkg`:
  - default timing constants (640x480@60)
  - `typedef logic [10:0] vga_coord_t`
  - `localparam COORD_W = 11`
- Sub-module `vga_axis_counter`, parameters ACTIVE/FP/SYNC/BP.
  - Inputs: `clk`, `rst`, `step`. Outputs: `count`, `wrap`, `active`, `sync_raw`.
  - Instantiated twice. Horizontal instance: `step`=pix_en. Vertical instance: `step`=pix_en & h_wrap.
- Top level holds the output registers and the sync delay pipeline.

## Test plan
- Reset release with `pix_en`=1 constant -> first edge: column=0, row=0, en=1, frame_start=1, line_start=1. Next edge: column=1, frame_start=0, line_start=0.
- Run to column=799, row=5 -> next edge shows column=0, row=6, line_start=1, en=1.
- Default parameters, SYNC_DELAY=1 -> hsync low for exactly 96 ticks, going low the edge after column=656 is presented. vsync low for exactly 1600 ticks (2 lines).
- Full frame -> en high for exactly 307200 ticks. frame_start period 420000 ticks. row never exceeds 524, column never exceeds 799.
- `pix_en` asserted 1 clk in 4 -> outputs change only on `pix_en` edges. frame_start and line_start stay exactly 1 clk wide. Frame period 1680000 clks.
- Assert `rst` asynchronously at column=300, row=200 -> without a clk edge, column=0, row=0, en=0, hsync=1, vsync=1. Release -> sequence restarts as in the first scenario.
